// File: rtl/uart_tx_engine.sv
// UART transmit engine: pops one word per frame from a synchronous FIFO
// (1-cycle read latency) and serialises it LSB-first with optional parity
// and one or two stop bits. The tx line is registered, so it cannot glitch.
module uart_tx_engine #(
    parameter int CLKS_PER_BIT = 50,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [1:0]           parity_mode,
    input  logic                 empty,
    input  logic [DATA_BITS-1:0] rd_data,
    output logic                 read_en,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int IDX_W = $clog2(DATA_BITS + 1);

    // Last count of one bit period, and of the whole stop period
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_LOAD   = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
        S_PARITY = 3'd5,
        S_STOP   = 3'd6
    } state_t;

    state_t               state, state_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic [IDX_W-1:0]     bit_idx, bit_idx_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic                 par_en, par_en_next;
    logic                 par_bit, par_bit_next;
    logic                 tx_next;
    logic                 bit_end;
    logic                 stop_end;
    logic                 cnt_clear;

    assign bit_end  = (cnt == BIT_LAST);
    assign stop_end = (cnt == STOP_LAST);

    // Strobes decoded straight from the state register
    assign read_en = (state == S_READ);
    assign busy    = state inside {S_READ, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP};
    assign tx_done = (state == S_STOP) && stop_end;

    // Next-state, datapath updates and the next value of the tx line
    always_comb begin
        // NOTE: every signal gets a default first, so no path can infer a latch.
        state_next   = state;
        shift_next   = shift;
        bit_idx_next = bit_idx;
        par_en_next  = par_en;
        par_bit_next = par_bit;
        cnt_clear    = 1'b0;

        case (state)
            S_IDLE: begin
                cnt_clear = 1'b1;
                if (enable && !empty) begin
                    state_next = S_READ;
                end
            end
            S_READ: begin
                cnt_clear  = 1'b1;
                state_next = S_LOAD;
            end
            S_LOAD: begin
                cnt_clear    = 1'b1;
                shift_next   = rd_data;
                bit_idx_next = '0;
                par_en_next  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
                par_bit_next = (parity_mode == 2'b10) ? ~^rd_data : ^rd_data;
                state_next   = S_START;
            end
            S_START: begin
                if (bit_end) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_clear    = 1'b1;
                    shift_next   = shift >> 1;
                    bit_idx_next = bit_idx + IDX_W'(1);
                    if (bit_idx == IDX_LAST) begin
                        state_next = par_en ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (stop_end) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                cnt_clear  = 1'b1;
                state_next = S_IDLE;
            end
        endcase

        cnt_next = (cnt_clear || (state_next != state)) ? '0 : cnt + CNT_W'(1);

        // tx is registered from the state being entered, so it lines up with state
        case (state_next)
            S_START:  tx_next = 1'b0;
            S_DATA:   tx_next = shift_next[0];
            S_PARITY: tx_next = par_bit_next;
            default:  tx_next = 1'b1;
        endcase
    end

    // State register and datapath registers; reset forces the line idle at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            par_en  <= 1'b0;
            par_bit <= 1'b0;
            tx      <= 1'b1;
        end else begin
            // NOTE: non-blocking so every register updates from the same pre-edge values.
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
            par_en  <= par_en_next;
            par_bit <= par_bit_next;
            tx      <= tx_next;
        end
    end

endmodule
